// File: rtl/digit_entry_buffer_pkg.sv
// Shared calculator datapath constants and the strobe-priority helper for the digit entry buffer.
package calc_pkg;

   localparam int DIGIT_W         = 4;
   localparam int DEPTH_DEFAULT   = 8;
   localparam int OVF_REJECT      = 0;
   localparam int OVF_DROP_OLDEST = 1;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_CLR,
      OP_BKSP,
      OP_PUSH
   } op_e;

   // clr beats bksp beats push; lower-priority pulses in the same cycle are dropped.
   function automatic op_e pick_op(input logic clr_p, input logic bksp_p, input logic push_p);
      if (clr_p)       return OP_CLR;
      else if (bksp_p) return OP_BKSP;
      else if (push_p) return OP_PUSH;
      else             return OP_NONE;
   endfunction

endpackage

// File: rtl/digit_entry_buffer_if.sv
// Key-strobe / digit-bus bundle between the key decoder and the digit entry buffer.
interface digit_entry_buffer_if
   import calc_pkg::*;
#(
   parameter int W     = DIGIT_W,
   parameter int DEPTH = DEPTH_DEFAULT
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                 push;
   logic                 bksp;
   logic                 clr;
   logic [W-1:0]         data;
   logic [DEPTH*W-1:0]   digits;
   logic [CW-1:0]        count;
   logic                 empty;
   logic                 full;
   logic                 ovf;

   modport master (
      output push, bksp, clr, data,
      input  digits, count, empty, full, ovf
   );

   modport slave (
      input  push, bksp, clr, data,
      output digits, count, empty, full, ovf
   );

endinterface

// File: rtl/digit_entry_buffer_strobe_sync.sv
// Two-flop synchroniser for an asynchronous key strobe, followed by a single-cycle rising-edge pulse.
module strobe_sync (
   input  logic clk,
   input  logic rst,
   input  logic strobe_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= strobe_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit-entry shift register: push / backspace / clear with configurable full behaviour.
// Optional leading-zero suppression is enabled by defining DIGIT_ENTRY_LZS_EN.
module digit_entry_buffer
   import calc_pkg::*;
#(
   parameter int W        = DIGIT_W,
   parameter int DEPTH    = DEPTH_DEFAULT,
   parameter int OVF_MODE = OVF_REJECT
) (
   input logic                 clk,
   input logic                 rst,
   digit_entry_buffer_if.slave bus
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][W-1:0] slot_q, slot_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    ovf_q, ovf_d;

   logic push_p, bksp_p, clr_p;
   logic full_w;
   logic lz_skip;
   op_e  op;

   strobe_sync u_sync_push (.clk(clk), .rst(rst), .strobe_i(bus.push), .pulse_o(push_p));
   strobe_sync u_sync_bksp (.clk(clk), .rst(rst), .strobe_i(bus.bksp), .pulse_o(bksp_p));
   strobe_sync u_sync_clr  (.clk(clk), .rst(rst), .strobe_i(bus.clr),  .pulse_o(clr_p));

   assign op     = pick_op(clr_p, bksp_p, push_p);
   assign full_w = (count_q == CW'(DEPTH));

`ifdef DIGIT_ENTRY_LZS_EN
   assign lz_skip = (bus.data == '0) && (count_q == '0);
`else
   assign lz_skip = 1'b0;
`endif

   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (op)
         OP_CLR: begin
            slot_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
         end
         OP_BKSP: begin
            if (count_q != '0) begin
               for (int unsigned i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
               slot_d[DEPTH-1] = '0;
               count_d         = count_q - CW'(1);
            end
         end
         OP_PUSH: begin
            if (!lz_skip) begin
               // Shifting when full in drop-oldest mode discards slot DEPTH-1 and keeps count at DEPTH.
               if (!full_w || (OVF_MODE == OVF_DROP_OLDEST)) begin
                  for (int unsigned i = DEPTH - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
                  slot_d[0] = bus.data;
               end
               if (full_w) ovf_d   = 1'b1;
               else        count_d = count_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.digits = slot_q;
   assign bus.count  = count_q;
   assign bus.empty  = (count_q == '0);
   assign bus.full   = full_w;
   assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: reject and drop-oldest instances driven in lockstep against a queue model.
module tb_digit_entry_buffer;

   localparam int W     = 4;
   localparam int DEPTH = 8;
`ifdef DIGIT_ENTRY_LZS_EN
   localparam bit LZS = 1'b1;
`else
   localparam bit LZS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic push, bksp, clr;
   logic [W-1:0] data;

   int vectors     = 0;
   int miscompares = 0;

   // Model: newest digit at index 0; index 0 = reject instance, 1 = drop-oldest instance.
   int unsigned mq0[$];
   int unsigned mq1[$];
   bit          mo0, mo1;

   always #5 clk = ~clk;

   digit_entry_buffer_if #(.W(W), .DEPTH(DEPTH)) if0 ();
   digit_entry_buffer_if #(.W(W), .DEPTH(DEPTH)) if1 ();

   assign if0.push = push;  assign if1.push = push;
   assign if0.bksp = bksp;  assign if1.bksp = bksp;
   assign if0.clr  = clr;   assign if1.clr  = clr;
   assign if0.data = data;  assign if1.data = data;

   digit_entry_buffer #(.W(W), .DEPTH(DEPTH), .OVF_MODE(0)) u_rej  (.clk(clk), .rst(rst), .bus(if0));
   digit_entry_buffer #(.W(W), .DEPTH(DEPTH), .OVF_MODE(1)) u_drop (.clk(clk), .rst(rst), .bus(if1));

   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq0.delete(); mq1.delete();
      mo0 = 1'b0;   mo1 = 1'b0;
   endtask

   task automatic model_step(input bit c, input bit b, input bit p, input int unsigned d);
      if (c) begin
         model_reset();
      end else if (b) begin
         if (mq0.size() > 0) void'(mq0.pop_front());
         if (mq1.size() > 0) void'(mq1.pop_front());
      end else if (p) begin
         if (!(LZS && d == 0 && mq0.size() == 0)) begin
            if (mq0.size() < DEPTH) mq0.push_front(d);
            else mo0 = 1'b1;
         end
         if (!(LZS && d == 0 && mq1.size() == 0)) begin
            if (mq1.size() < DEPTH) mq1.push_front(d);
            else begin
               mq1.push_front(d);
               void'(mq1.pop_back());
               mo1 = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [DEPTH*W-1:0] expect_digits(input int m);
      logic [DEPTH*W-1:0] v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (m == 0 && i < mq0.size()) v[i*W +: W] = W'(mq0[i]);
         if (m == 1 && i < mq1.size()) v[i*W +: W] = W'(mq1[i]);
      end
      return v;
   endfunction

   task automatic check_all(input string tag);
      int n0 = mq0.size();
      int n1 = mq1.size();
      cmp({tag, "/rej.digits"},  64'(if0.digits), 64'(expect_digits(0)));
      cmp({tag, "/rej.count"},   64'(if0.count),  64'(n0));
      cmp({tag, "/rej.empty"},   64'(if0.empty),  64'(n0 == 0));
      cmp({tag, "/rej.full"},    64'(if0.full),   64'(n0 == DEPTH));
      cmp({tag, "/rej.ovf"},     64'(if0.ovf),    64'(mo0));
      cmp({tag, "/drop.digits"}, 64'(if1.digits), 64'(expect_digits(1)));
      cmp({tag, "/drop.count"},  64'(if1.count),  64'(n1));
      cmp({tag, "/drop.empty"},  64'(if1.empty),  64'(n1 == 0));
      cmp({tag, "/drop.full"},   64'(if1.full),   64'(n1 == DEPTH));
      cmp({tag, "/drop.ovf"},    64'(if1.ovf),    64'(mo1));
   endtask

   // Raise strobes before edge k; outputs must be unchanged after k+1 and updated after k+2.
   task automatic strobe(input string tag, input bit c, input bit b, input bit p, input int unsigned d);
      @(negedge clk);
      clr = c; bksp = b; push = p; data = W'(d);
      @(posedge clk);
      @(posedge clk); #1;
      check_all({tag, "/early"});
      @(posedge clk); #1;
      model_step(c, b, p, d);
      check_all(tag);
      @(negedge clk);
      clr = 1'b0; bksp = 1'b0; push = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; bksp = 1'b0; clr = 1'b0; data = '0;
      model_reset();
      repeat (3) @(posedge clk); #1;
      check_all("reset");
      cmp("reset_empty", 64'(if0.empty), 64'd1);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);

      strobe("push3", 0, 0, 1, 3);
      strobe("push5", 0, 0, 1, 5);
      strobe("push7", 0, 0, 1, 7);
      cmp("p357_digits", 64'(if0.digits), 64'h0000_0357);
      cmp("p357_count",  64'(if0.count),  64'd3);

      strobe("bksp1", 0, 1, 0, 0);
      strobe("bksp2", 0, 1, 0, 0);
      cmp("bksp_digits", 64'(if0.digits), 64'h0000_0003);
      strobe("bksp3", 0, 1, 0, 0);
      strobe("bksp4_empty", 0, 1, 0, 0);
      cmp("bksp_underflow", 64'(if1.count), 64'd0);

      for (int unsigned d = 1; d <= 8; d++) strobe("fill", 0, 0, 1, d);
      strobe("push9_full", 0, 0, 1, 9);
      cmp("ovf_rej_digits",  64'(if0.digits), 64'h1234_5678);
      cmp("ovf_drop_digits", 64'(if1.digits), 64'h2345_6789);
      cmp("ovf_drop_ovf",    64'(if1.ovf),    64'd1);

      repeat (4) strobe("trim", 0, 1, 0, 0);
      cmp("trim_ovf_kept", 64'(if0.ovf), 64'd1);
      strobe("clr_push", 1, 0, 1, 5);
      strobe("bksp_push", 0, 1, 1, 2);
      strobe("push_after", 0, 0, 1, 6);

      // Held level: exactly one digit, then async reset while still held.
      strobe("clr_pre_hold", 1, 0, 0, 0);
      @(negedge clk);
      push = 1'b1; data = 4'd6;
      repeat (20) @(posedge clk); #1;
      model_step(0, 0, 1, 6);
      check_all("hold");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      push = 1'b0;
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);

      if (LZS) begin
         strobe("lzs_zero_empty", 0, 0, 1, 0);
         strobe("lzs_push4", 0, 0, 1, 4);
         strobe("lzs_push0", 0, 0, 1, 0);
         cmp("lzs_digits", 64'(if0.digits), 64'h0000_0040);
      end else begin
         strobe("zero_empty", 0, 0, 1, 0);
         cmp("zero_count", 64'(if0.count), 64'd1);
      end

      for (int n = 0; n < 250; n++) begin
         bit c, b, p;
         c = ($urandom_range(0, 19) == 0);
         b = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 2) != 0);
         if (!c && !b && !p) p = 1'b1;
         strobe("rand", c, b, p, $urandom_range(0, 15));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/digit_entry_buffer.md
Name: digit_entry_buffer

Overview:
Parametrised keypad digit-entry register for the calculator datapath. It is the successor to the fixed 6x8 operand shift register and runs synchronously on the system clock. Key strobes are synchronised and edge-detected internally. It supports push, backspace (remove newest digit) and clear, with selectable behaviour when full. Its outputs feed the operand converter and the display driver.

Parameters:
W, 4, bits per digit code
DEPTH, 8, number of digit slots (>=2)
OVF_MODE, 0, push when full: 0 = reject, 1 = discard oldest digit and accept the new one
CW, $clog2(DEPTH+1), count width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
push  in  1  asynchronous level strobe from key decoder; rising edge = enter digit
bksp  in  1  asynchronous level strobe; rising edge = delete newest digit
clr  in  1  asynchronous level strobe; rising edge = clear all digits
data  in  W  digit code; must be stable from push rise until 3 clk edges later
digits  out  DEPTH*W  slot i at [i*W +: W]; slot 0 = newest
count  out  CW  number of valid digits, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
ovf  out  1  sticky; a push arrived while full

Behaviour:
- Reset (rst=1, async): all slots 0, count=0, ovf=0, synchroniser flops 0. Therefore empty=1 and full=0.
- Strobe path, per input:
  - 2-flop synchroniser, then a previous-value flop.
  - pulse = sync2 & ~prev.
  - A rising input sampled at clk edge k produces a pulse in the cycle after edge k+1. The register updates at edge k+2.
  - A held level produces exactly one pulse.
- Priority when pulses coincide in one cycle: clr > bksp > push. Lower-priority pulses are dropped.
- clr: all slots 0, count=0, ovf=0.
- bksp:
  - If count>0: slot[i] <= slot[i+1] for i<DEPTH-1, slot[DEPTH-1] <= 0, count-1.
  - If empty: no change.
  - ovf is unchanged.
- push with count<DEPTH: slot[i] <= slot[i-1] for i>0, slot[0] <= data, count+1.
- push with count==DEPTH:
  - OVF_MODE=0: slots and count unchanged, ovf <= 1.
  - OVF_MODE=1: shift as a normal push (oldest digit lost), count stays DEPTH, ovf <= 1.
- Slots at index >= count are always 0.
- All outputs are registered or simple decodes of registers. There is no combinational path from inputs to outputs.
- If rst asserts mid-sequence, it overrides everything. In-flight pulses are lost.

Optional Feature:
- Macro DIGIT_ENTRY_LZS_EN (leading-zero suppression).
- Defined: a push with data==0 while count==0 is ignored. Slots, count and ovf are unchanged.
- Undefined: a zero is accepted like any other digit.

Decomposition:
- Shared package calc_pkg: DIGIT_W default, DEPTH default, OVF_REJECT=0 / OVF_DROP_OLDEST=1 constants.
- Sub-module strobe_sync: 2-flop synchroniser plus rising-edge pulse, async rst. Instantiated three times (push, bksp, clr).
- Top holds the slot array, count, ovf and priority logic.

Test Plan:
- Reset then push 3,5,7 (W=4, DEPTH=8) -> slot0=7, slot1=5, slot2=3, count=3, empty=0, full=0. Each update lands 3 edges after the push rise.
- Push 1..8, then push 9 with OVF_MODE=0 -> slots unchanged (slot0=8, slot7=1), count=8, full=1, ovf=1. Repeat with OVF_MODE=1 -> slot0=9, slot7=2, count=8, ovf=1.
- After 7,5,3 entered: bksp twice -> slot0=3, slot1..7=0, count=1. Two further bksp -> count=0, empty=1, no underflow.
- Raise clr and push in the same clk cycle with count=4, ovf=1 -> all slots 0, count=0, ovf=0, and push dropped.
- Hold push high for 20 cycles with data=6 -> exactly one digit entered, count=1. Assert rst mid-hold -> all outputs return to reset values asynchronously.
- With DIGIT_ENTRY_LZS_EN defined: push 0 when empty -> count=0. Then push 4, then 0 -> slot0=0, slot1=4, count=2.
